// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch front end.
// Issues one-outstanding sequential fetches to a variable-latency instruction
// memory, buffers returned words with their NPC in a DEPTH-entry FIFO and
// hands them to decode over a valid/ready handshake. An MA-stage redirect
// flushes the queue and any in-flight fetch.
// Optional macro IFQ_BYPASS_EN: when the queue is empty, a returning word
// goes straight to decode in the same cycle instead of being enqueued.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_npc,
  input  logic        inst_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     req_addr_q, req_addr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     q_inst_q [DEPTH];
  logic [31:0]     q_npc_q  [DEPTH];

  logic            ack_eff;
  logic            live_ack;
  logic            q_valid;
  logic            bypass;
  logic            push;
  logic            pop;

  // Address increment wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Request generation, handshake decode and head presentation.
  always_comb begin
    mem_req  = !RST && (((state_q == IDLE) && (count_q < CW'(DEPTH)) && !redirect)
                        || (state_q == WAIT) || (state_q == DROP));
    // In DROP the in-flight request keeps its original address even though
    // fetch_pc already points at the redirect target.
    mem_addr = (state_q == DROP) ? req_addr_q : fetch_pc_q;
    ack_eff  = mem_ack && mem_req;
    live_ack = ack_eff && (state_q != DROP) && !redirect;
    q_valid  = (count_q != '0);
`ifdef IFQ_BYPASS_EN
    bypass   = live_ack && !q_valid && inst_ready;
`else
    bypass   = 1'b0;
`endif
    push     = live_ack && !bypass;
    pop      = q_valid && inst_ready && !redirect;

    inst_valid = 1'b0;
    inst       = 32'h0;
    inst_npc   = 32'h0;
    if (!RST) begin
      if (bypass) begin
        inst_valid = 1'b1;
        inst       = mem_rdata;
        inst_npc   = pc_inc(fetch_pc_q);
      end else if (q_valid) begin
        inst_valid = 1'b1;
        inst       = q_inst_q[rd_ptr_q];
        inst_npc   = q_npc_q[rd_ptr_q];
      end
    end
  end

  // Next-state for the fetch FSM, fetch PC and queue bookkeeping.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = (state_q == IDLE) ? fetch_pc_q : req_addr_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    unique case (state_q)
      IDLE: if (mem_req && !mem_ack) state_d = WAIT;
      WAIT: begin
        if (redirect)     state_d = mem_ack ? IDLE : DROP;
        else if (mem_ack) state_d = IDLE;
      end
      DROP: if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (live_ack) fetch_pc_d = pc_inc(fetch_pc_q);
      if (push)     wr_ptr_d   = wr_ptr_q + PW'(1);
      if (pop)      rd_ptr_d   = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers and queue storage, cleared by synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_inst_q[i] <= 32'h0;
        q_npc_q[i]  <= 32'h0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push) begin
        q_inst_q[wr_ptr_q] <= mem_rdata;
        q_npc_q[wr_ptr_q]  <= pc_inc(fetch_pc_q);
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed testbench for ifetch_queue (default build, bypass disabled).
// Memory model returns rdata = addr ^ 32'hA5A5_0000, acking either
// combinationally (zero-wait mode) or under direct bench control.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_npc;
  logic        inst_ready = 1'b1;

  logic        zw = 1'b1;
  logic        ack_man = 1'b0;

  int checks   = 0;
  int failures = 0;

  assign mem_ack   = zw ? mem_req : ack_man;
  assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .CLK(clk), .RST(rst),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_npc(inst_npc),
    .inst_ready(inst_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    cyc();
    cyc();
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst",  inst,            32'h0);
    chk("rst_npc",   inst_npc,        32'h0);
    chk("rst_req",   32'(mem_req),    32'h0);

    // Zero-wait streaming after reset release
    rst = 1'b0;
    #1;
    chk("zw_addr0",  mem_addr,        32'h0);
    chk("zw_req0",   32'(mem_req),    32'h1);
    chk("zw_valid0", 32'(inst_valid), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("zw_addr",  mem_addr,        32'(4 * i));
      chk("zw_valid", 32'(inst_valid), 32'h1);
      chk("zw_inst",  inst,            32'hA5A5_0000 ^ 32'(4 * (i - 1)));
      chk("zw_npc",   inst_npc,        32'(4 * i));
    end

    // Stall from a fresh reset: 4 pushes then requests stop
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    inst_ready = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("stall_req", 32'(mem_req), (i < 4) ? 32'h1 : 32'h0);
      if (i < 4) chk("stall_addr", mem_addr, 32'(4 * i));
      cyc();
    end
    chk("stall_head", inst, 32'hA5A5_0000);
    inst_ready = 1'b1;
    #1;
    chk("drain_req_full", 32'(mem_req), 32'h0);
    chk("drain_inst0",    inst,         32'hA5A5_0000);
    chk("drain_npc0",     inst_npc,     32'h4);
    cyc();
    chk("resume_addr", mem_addr, 32'h10);
    chk("drain_inst1", inst,     32'hA5A5_0004);
    cyc();
    chk("drain_inst2", inst,     32'hA5A5_0008);
    cyc();
    chk("drain_inst3", inst,     32'hA5A5_000C);
    chk("drain_npc3",  inst_npc, 32'h10);
    cyc();
    chk("drain_inst4", inst,     32'hA5A5_0010);

    // Variable latency: request 0x10 acked on its third cycle
    redirect = 1'b1;
    redirect_pc = 32'h10;
    #1;
    chk("redir_idle_req", 32'(mem_req), 32'h0);
    cyc();
    redirect = 1'b0;
    zw = 1'b0;
    ack_man = 1'b0;
    #1;
    chk("vl_flush_valid", 32'(inst_valid), 32'h0);
    chk("vl_addr_c1", mem_addr, 32'h10);
    cyc();
    chk("vl_addr_c2", mem_addr, 32'h10);
    chk("vl_req_c2",  32'(mem_req), 32'h1);
    cyc();
    ack_man = 1'b1;
    #1;
    chk("vl_addr_c3", mem_addr, 32'h10);
    cyc();
    ack_man = 1'b0;
    #1;
    chk("vl_valid", 32'(inst_valid), 32'h1);
    chk("vl_inst",  inst,            32'hA5A5_0010);
    chk("vl_npc",   inst_npc,        32'h14);
    chk("vl_next_addr", mem_addr,    32'h14);

    // Redirect during an outstanding request to 0x20
    redirect = 1'b1;
    redirect_pc = 32'h20;
    cyc();
    redirect = 1'b0;
    #1;
    chk("rm_addr_c0", mem_addr, 32'h20);
    cyc();
    redirect = 1'b1;
    redirect_pc = 32'h103;
    #1;
    chk("rm_addr_c1", mem_addr, 32'h20);
    cyc();
    redirect = 1'b0;
    #1;
    chk("rm_valid_after", 32'(inst_valid), 32'h0);
    chk("rm_drop_addr",   mem_addr,        32'h20);
    chk("rm_drop_req",    32'(mem_req),    32'h1);
    cyc();
    ack_man = 1'b1;
    #1;
    chk("rm_drop_addr2", mem_addr, 32'h20);
    cyc();
    ack_man = 1'b0;
    zw = 1'b1;
    #1;
    chk("rm_new_addr",    mem_addr,        32'h100);
    chk("rm_stale_valid", 32'(inst_valid), 32'h0);
    cyc();
    chk("rm_inst", inst,     32'hA5A5_0100);
    chk("rm_npc",  inst_npc, 32'h104);

    // Redirect coincident with mem_ack and a pop
    zw = 1'b0;
    ack_man = 1'b0;
    inst_ready = 1'b0;
    cyc();
    inst_ready = 1'b1;
    ack_man = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    #1;
    chk("co_valid_before", 32'(inst_valid), 32'h1);
    chk("co_addr",         mem_addr,        32'h104);
    cyc();
    redirect = 1'b0;
    ack_man = 1'b0;
    zw = 1'b1;
    #1;
    chk("co_valid_after", 32'(inst_valid), 32'h0);
    chk("co_new_addr",    mem_addr,        32'h200);
    cyc();
    chk("co_inst", inst,     32'hA5A5_0200);
    chk("co_npc",  inst_npc, 32'h204);

    // Address wrap at the top of the space
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    #1;
    chk("wrap_addr0",  mem_addr,        32'hFFFF_FFFC);
    chk("wrap_valid0", 32'(inst_valid), 32'h0);
    cyc();
    chk("wrap_addr1", mem_addr, 32'h0);
    chk("wrap_inst",  inst,     32'h5A5A_FFFC);
    chk("wrap_npc",   inst_npc, 32'h0);

    // Reset while WAIT with two entries queued
    inst_ready = 1'b0;
    cyc();
    zw = 1'b0;
    ack_man = 1'b0;
    cyc();
    chk("rw_req_wait", 32'(mem_req),    32'h1);
    chk("rw_valid",    32'(inst_valid), 32'h1);
    chk("rw_inst",     inst,            32'h5A5A_FFFC);
    rst = 1'b1;
    cyc();
    chk("rw_rst_valid", 32'(inst_valid), 32'h0);
    chk("rw_rst_req",   32'(mem_req),    32'h0);
    rst = 1'b0;
    zw = 1'b1;
    #1;
    chk("rw_post_addr",  mem_addr,        32'h0);
    chk("rw_post_req",   32'(mem_req),    32'h1);
    chk("rw_post_valid", 32'(inst_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
